// File: rtl/uart_pkg.sv
// Shared UART constants: character width and receive FIFO sizing used by the
// receiver, transmitter, register block and the receive buffer.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_AFULL = 12;

  // Pointer action taken by the receive FIFO on one clock edge.
  typedef enum logic [1:0] {
    FIFO_OP_IDLE = 2'b00,
    FIFO_OP_PUSH = 2'b01,
    FIFO_OP_POP  = 2'b10,
    FIFO_OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array for the receive FIFO: synchronous write,
// asynchronous read so the head entry falls through without an extra cycle.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int DataWidth = 8,
  parameter int Depth     = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [DataWidth-1:0]     wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [DataWidth-1:0]     rdata_o
);

  logic [DataWidth-1:0] mem [Depth];

  // Write port: one entry per accepted byte.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures byte strobes into a
// circular FIFO and presents them first-word-fall-through on a valid/ready
// port, with level, empty/full/almost-full and a sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DataWidth       = UART_DATA_W,
  parameter int Depth           = RX_FIFO_DEPTH,
  parameter int AlmostFullLevel = RX_FIFO_AFULL
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DataWidth-1:0]     push_data_i,
  input  logic                     clr_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [DataWidth-1:0]     rd_data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic                     overrun_o
);

  localparam int AW = $clog2(Depth);
  localparam int PW = AW + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  // when the indices coincide.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          overrun_q;

  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  fifo_op_e      op;

  // Decode this cycle's pointer action; a pop frees the slot a full-FIFO push needs.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    do_pop  = rd_ready_i && !empty;
    do_push = push_i && (!full || do_pop);
    drop    = push_i && full && !do_pop;
    op      = fifo_op_e'({do_pop, do_push});
  end

  // Pointer and overrun state; flush outranks any coincident push or pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_q <= 1'b0;
    end else if (clr_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_q <= 1'b0;
    end else begin
      unique case (op)
        FIFO_OP_PUSH: wr_ptr <= wr_ptr + PW'(1);
        FIFO_OP_POP:  rd_ptr <= rd_ptr + PW'(1);
        FIFO_OP_BOTH: begin
          wr_ptr <= wr_ptr + PW'(1);
          rd_ptr <= rd_ptr + PW'(1);
        end
        default: ;
      endcase
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (do_push && !clr_i),
    .waddr_i (wr_ptr[AW-1:0]),
    .wdata_i (push_data_i),
    .raddr_i (rd_ptr[AW-1:0]),
    .rdata_o (rd_data_o)
  );

  // Status is derived only from registered pointers, never from push_i/rd_ready_i.
  assign count_o       = wr_ptr - rd_ptr;
  assign empty_o       = empty;
  assign full_o        = full;
  assign rd_valid_o    = !empty;
  assign almost_full_o = (count_o >= PW'(AlmostFullLevel));
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus randomized traffic,
// checked by a queue-based reference model and a decoupled read monitor.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_i = 1'b0;
  logic [DW-1:0] push_data_i = '0;
  logic          clr_i = 1'b0;
  logic          rd_ready_i = 1'b0;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic [4:0]    count_o;
  logic          empty_o, full_o, almost_full_o, overrun_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an occupancy count, a sticky overrun bit and the queue
  // of bytes the consumer is expected to receive, in order.
  int       model_cnt = 0;
  bit       model_ovr = 1'b0;
  logic [DW-1:0] exp_q[$];

  uart_rx_fifo #(
    .DataWidth       (DW),
    .Depth           (DEPTH),
    .AlmostFullLevel (AFULL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (push_i),
    .push_data_i   (push_data_i),
    .clr_i         (clr_i),
    .rd_valid_o    (rd_valid_o),
    .rd_ready_i    (rd_ready_i),
    .rd_data_o     (rd_data_o),
    .count_o       (count_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each active edge (or immediately on reset).
  always @(posedge clk or posedge rst) begin
    bit pop, acc;
    if (rst) begin
      model_cnt = 0;
      model_ovr = 1'b0;
      exp_q.delete();
    end else if (clr_i) begin
      model_cnt = 0;
      model_ovr = 1'b0;
      exp_q.delete();
    end else begin
      pop = rd_ready_i && (model_cnt > 0);
      acc = push_i && ((model_cnt < DEPTH) || pop);
      if (push_i && !acc) model_ovr = 1'b1;
      if (acc) exp_q.push_back(push_data_i);
      model_cnt = model_cnt + int'(acc) - int'(pop);
    end
  end

  // Monitor: mid-cycle, compare status with the model and check each
  // consumed byte against the head of the expected queue.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst) begin
      chk("mon_count", 32'(count_o), 32'(model_cnt));
      chk("mon_valid", 32'(rd_valid_o), 32'(model_cnt != 0));
      chk("mon_empty", 32'(empty_o), 32'(model_cnt == 0));
      chk("mon_full", 32'(full_o), 32'(model_cnt == DEPTH));
      chk("mon_afull", 32'(almost_full_o), 32'(model_cnt >= AFULL));
      chk("mon_overrun", 32'(overrun_o), 32'(model_ovr));
      if (rd_valid_o && rd_ready_i && !clr_i) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pop", 32'(rd_data_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 32'(rd_data_o), 32'(e));
        end
      end
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the edge consumed them.
  task automatic tick(input bit p, input logic [DW-1:0] d, input bit r, input bit c);
    push_i      = p;
    push_data_i = d;
    rd_ready_i  = r;
    clr_i       = c;
    @(posedge clk);
    #1;
    push_i     = 1'b0;
    rd_ready_i = 1'b0;
    clr_i      = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && !empty_o; i++) tick(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 32'(empty_o), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] seq;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_afull", 32'(almost_full_o), 0);
    chk("rst_valid", 32'(rd_valid_o), 0);
    chk("rst_overrun", 32'(overrun_o), 0);

    // Single byte, one-cycle latency, then pop.
    tick(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_valid", 32'(rd_valid_o), 1);
    chk("a5_data", 32'(rd_data_o), 32'hA5);
    chk("a5_count", 32'(count_o), 1);
    tick(1'b0, '0, 1'b1, 1'b0);
    chk("a5_pop_empty", 32'(empty_o), 1);
    chk("a5_pop_count", 32'(count_o), 0);

    // Fill to full, watching the almost-full threshold.
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == AFULL - 2) chk("afull_below", 32'(almost_full_o), 0);
      if (i == AFULL - 1) chk("afull_at", 32'(almost_full_o), 1);
    end
    chk("fill_full", 32'(full_o), 1);
    chk("fill_count", 32'(count_o), DEPTH);

    // Push into a full FIFO without a pop: dropped.
    tick(1'b1, 8'h55, 1'b0, 1'b0);
    chk("ovr_flag", 32'(overrun_o), 1);
    chk("ovr_count", 32'(count_o), DEPTH);
    chk("ovr_head", 32'(rd_data_o), 32'h00);

    // Flush clears level and overrun.
    tick(1'b0, '0, 1'b0, 1'b1);
    chk("clr_count", 32'(count_o), 0);
    chk("clr_overrun", 32'(overrun_o), 0);

    // Refill, then push and pop together while full.
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    tick(1'b1, 8'h77, 1'b1, 1'b0);
    chk("both_overrun", 32'(overrun_o), 0);
    chk("both_count", 32'(count_o), DEPTH);
    chk("both_head", 32'(rd_data_o), 32'h01);
    drain();

    // Continuous pushes with incrementing data and random ready.
    seq = 8'h20;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, seq, ($urandom_range(3) != 0), 1'b0);
      seq++;
    end
    drain();
    chk("stream_overrun", 32'(overrun_o), 0);

    // Reset with entries held.
    for (int i = 0; i < 5; i++) tick(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mrst_count", 32'(count_o), 0);
    chk("mrst_valid", 32'(rd_valid_o), 0);
    chk("mrst_empty", 32'(empty_o), 1);
    chk("mrst_overrun", 32'(overrun_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("mrst_new_data", 32'(rd_data_o), 32'hC3);
    chk("mrst_new_count", 32'(count_o), 1);
    drain();

    // Random mixed traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(9) < 6), 8'($urandom), ($urandom_range(9) < 4),
           ($urandom_range(63) == 0));
    end
    drain();
    chk("sb_leftover", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
